// File: rtl/rbus_frame_arbiter.sv
// N-to-1 frame-granular rbus arbiter: a grant covers one whole frame (header + payload),
// winners chosen by header priority (optional) then round-robin, one registered output stage.
module rbus_frame_arbiter #(
  parameter int unsigned N       = 4,
  parameter bit          PRIO_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      i_valid,
  input  logic [N*72-1:0]   i_data,
  output logic [N-1:0]      i_ready,
  output logic              o_valid,
  output logic [71:0]       o_data,
  input  logic              o_ready,
  output logic [N-1:0]      o_grant,
  output logic              o_busy
);

  localparam int unsigned WW      = 72;
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW      = 4;
  localparam int unsigned LEN_BIT = 39;
  localparam int unsigned PRIO_LO = 68;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   rr_q;
  logic [CW-1:0]   cnt_q;

  logic [WW-1:0]   word [N];
  logic [1:0]      prio [N];
  logic [1:0]      max_prio;
  logic [IW:0]     scan_idx;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            accept;

  // Per-requester word view and header priority field
  always_comb begin
    for (int unsigned r = 0; r < N; r++) begin
      word[r] = i_data[WW*r +: WW];
      prio[r] = word[r][PRIO_LO +: 2];
    end
  end

  // Highest priority among requesters presenting a header
  always_comb begin
    max_prio = '0;
    for (int unsigned r = 0; r < N; r++) begin
      if (i_valid[r] && (prio[r] > max_prio)) begin
        max_prio = prio[r];
      end
    end
  end

  // Round-robin scan from rr_q; with priority enabled only max-priority requesters qualify
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = {1'b0, rr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(N)) begin
        scan_idx = scan_idx - (IW+1)'(N);
      end
      if (!pick_found && i_valid[scan_idx[IW-1:0]] &&
          (!PRIO_EN || (prio[scan_idx[IW-1:0]] == max_prio))) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[IW-1:0];
      end
    end
  end

  // A word moves when the owner presents one and the output stage is free or draining
  assign accept = (state_q == XFER) && i_valid[win_q] && (!o_valid || o_ready);

  always_comb begin
    i_ready        = '0;
    i_ready[win_q] = accept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_grant <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
          end
          if (pick_found) begin
            state_q <= XFER;
            o_busy  <= 1'b1;
            win_q   <= pick_idx;
            o_grant <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            cnt_q   <= word[pick_idx][LEN_BIT] ? CW'(8) : CW'(1);
          end
        end
        XFER: begin
          if (accept) begin
            o_data  <= word[win_q];
            o_valid <= 1'b1;
            if (cnt_q == '0) begin
              state_q <= IDLE;
              o_busy  <= 1'b0;
              o_grant <= '0;
              rr_q    <= (win_q == IW'(N-1)) ? '0 : win_q + IW'(1);
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end else if (o_ready) begin
            o_valid <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rbus_frame_arbiter.sv
// Bench for rbus_frame_arbiter: directed scenarios plus random traffic, checked against a
// frame-level model (per-requester frame queues, priority/round-robin winner rule, output scoreboard).
module tb_rbus_frame_arbiter;

  localparam int N = 4;
  localparam int W = 72;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     i_valid;
  logic [N*W-1:0]   i_data;
  logic [N-1:0]     i_ready;
  logic             o_valid;
  logic [W-1:0]     o_data;
  logic             o_ready;
  logic [N-1:0]     o_grant;
  logic             o_busy;

  always #5 clk = ~clk;

  rbus_frame_arbiter #(.N(N), .PRIO_EN(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] req_q [N][$];
  logic [W-1:0] exp_q [$];
  int           grant_log [$];
  int           exp_log [$];
  int           hold [N];
  int           rr_m, cur, left, flen;
  int           gap_req, gap_after, gap_len;
  int           ready_mode, vdrop;
  bit           rst_now, ready_t;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v = '0;
    if (r >= 0) v[r] = 1'b1;
    return v;
  endfunction

  task automatic add_frame(input int r, input logic [1:0] prio, input bit long_f);
    logic [W-1:0] h;
    h = rnd_word();
    h[69:68] = prio;
    h[39]    = long_f;
    req_q[r].push_back(h);
    for (int i = 0; i < (long_f ? 8 : 1); i++) req_q[r].push_back(rnd_word());
  endtask

  // Winner rule: highest header priority among valid requesters, ties from rr pointer onward
  function automatic int model_pick();
    int maxp;
    int idx;
    maxp = -1;
    for (int r = 0; r < N; r++)
      if (i_valid[r] && int'(i_data[W*r+68 +: 2]) > maxp) maxp = int'(i_data[W*r+68 +: 2]);
    if (maxp < 0) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr_m + k) % N;
      if (i_valid[idx] && int'(i_data[W*idx+68 +: 2]) == maxp) return idx;
    end
    return -1;
  endfunction

  function automatic bit all_done();
    for (int r = 0; r < N; r++) if (req_q[r].size() != 0) return 1'b0;
    return (cur < 0) && (exp_q.size() == 0) && !o_valid;
  endfunction

  // One clock: drive at negedge, check combinational/consumed outputs, advance model after posedge
  task automatic cycle();
    int           w_new;
    bit           acc, take, pv, pr, v;
    logic [W-1:0] acc_w, pd;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst_n = !rst_now;
    case (ready_mode)
      0:       o_ready = 1'b1;
      1:       begin o_ready = ready_t; ready_t = !ready_t; end
      default: o_ready = ($urandom_range(99) < 60);
    endcase
    for (int r = 0; r < N; r++) begin
      v = req_q[r].size() > 0;
      if (hold[r] > 0) begin
        v = 1'b0;
        hold[r]--;
      end else if (vdrop > 0 && $urandom_range(99) < vdrop) begin
        v = 1'b0;
      end
      i_valid[r] = v;
      i_data[W*r +: W] = v ? req_q[r][0] : rnd_word();
    end
    #1;
    pv = o_valid;
    pr = o_ready;
    pd = o_data;
    exp_rdy = '0;
    if (cur >= 0 && i_valid[cur] && (!o_valid || o_ready)) exp_rdy = oh(cur);
    if (!rst_now) check("i_ready", W'(i_ready), W'(exp_rdy));
    acc   = (exp_rdy != '0) && !rst_now;
    acc_w = acc ? req_q[cur][0] : '0;
    take  = o_valid && o_ready && !rst_now;
    if (take) begin
      if (exp_q.size() == 0) check("spurious_out", W'(1), W'(0));
      else check("out_order", o_data, exp_q.pop_front());
    end
    w_new = (cur < 0) ? model_pick() : -1;
    @(posedge clk);
    #1;
    if (rst_now) begin
      if (cur >= 0) repeat (left) void'(req_q[cur].pop_front());
      cur = -1; left = 0; rr_m = 0;
      exp_q.delete();
      check("rst_valid", W'(o_valid), W'(0));
      check("rst_data",  o_data,      W'(0));
      check("rst_grant", W'(o_grant), W'(0));
      check("rst_busy",  W'(o_busy),  W'(0));
      return;
    end
    if (acc) begin
      void'(req_q[cur].pop_front());
      left--;
      check("lat_valid", W'(o_valid), W'(1));
      check("lat_data",  o_data,      acc_w);
      if (gap_req == cur && flen - left == gap_after) hold[cur] = gap_len;
      if (left == 0) begin
        rr_m = (cur + 1) % N;
        cur  = -1;
        check("grant_end", W'(o_grant), W'(0));
        check("busy_end",  W'(o_busy),  W'(0));
      end else begin
        check("grant_hold", W'(o_grant), W'(oh(cur)));
      end
    end else begin
      check("hold_valid", W'(o_valid), W'(pv && !pr));
      if (pv && !pr) check("hold_data", o_data, pd);
      if (w_new >= 0) begin
        cur  = w_new;
        flen = req_q[cur][0][39] ? 9 : 2;
        left = flen;
        for (int i = 0; i < flen; i++) exp_q.push_back(req_q[cur][i]);
        grant_log.push_back(cur);
        check("grant_start", W'(o_grant), W'(oh(cur)));
        check("busy_start",  W'(o_busy),  W'(1));
      end else if (cur >= 0) begin
        check("grant_gap", W'(o_grant), W'(oh(cur)));
        check("busy_gap",  W'(o_busy),  W'(1));
      end else begin
        check("grant_idle", W'(o_grant), W'(0));
        check("busy_idle",  W'(o_busy),  W'(0));
      end
    end
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_done()) begin
      cycle();
      n++;
    end
    check({tag, "_drain"}, W'(n < budget), W'(1));
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nframes"}, W'(grant_log.size()), W'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < grant_log.size(); i++)
      check({tag, "_order"}, W'(grant_log[i]), W'(exp_log[i]));
    grant_log.delete();
  endtask

  initial begin
    logic [W-1:0] h;
    int n;
    rst_n = 1'b0; i_valid = '0; i_data = '0; o_ready = 1'b0;
    cur = -1; left = 0; flen = 0; rr_m = 0;
    gap_req = -1; gap_after = 0; gap_len = 0;
    ready_mode = 0; vdrop = 0; ready_t = 1'b1;
    for (int r = 0; r < N; r++) hold[r] = 0;

    // Reset, then quiet outputs
    rst_now = 1'b1;
    cycle();
    cycle();
    rst_now = 1'b0;
    cycle();
    check("idle_valid", W'(o_valid), W'(0));
    check("idle_data",  o_data,      W'(0));

    // Single short frame from r2 with payload A5
    h = rnd_word(); h[39] = 1'b0;
    req_q[2].push_back(h);
    req_q[2].push_back(W'(64'hA5));
    run("short_r2", 20);
    exp_log = '{2};
    check_log("short_r2");

    // Reset in the middle of a long frame after its third word
    add_frame(0, 2'd1, 1'b1);
    n = 0;
    while (n < 20 && !(cur == 0 && flen - left == 3)) begin
      cycle();
      n++;
    end
    check("midrst_reach", W'(n < 20), W'(1));
    rst_now = 1'b1;
    cycle();
    rst_now = 1'b0;
    cycle();
    check("midrst_valid", W'(o_valid), W'(0));
    grant_log.delete();

    // Equal priority, long frames: round-robin order
    for (int r = 0; r < N; r++) add_frame(r, 2'd1, 1'b1);
    add_frame(0, 2'd1, 1'b1);
    run("rr_equal", 200);
    exp_log = '{0, 1, 2, 3, 0};
    check_log("rr_equal");

    // Priority beats round-robin position
    add_frame(0, 2'd0, 1'b0);
    add_frame(3, 2'd3, 1'b0);
    run("prio", 40);
    exp_log = '{3, 0};
    check_log("prio");

    // Alternating backpressure on a long frame
    ready_mode = 1;
    add_frame(1, 2'd2, 1'b1);
    run("bp_toggle", 80);
    exp_log = '{1};
    check_log("bp_toggle");
    ready_mode = 0;

    // Owner gap of 5 cycles after word 4 while r0 waits
    gap_req = 1; gap_after = 4; gap_len = 5;
    add_frame(1, 2'd3, 1'b1);
    add_frame(0, 2'd0, 1'b1);
    run("gap", 80);
    exp_log = '{1, 0};
    check_log("gap");
    gap_req = -1;

    // Random traffic: random owners, priorities, lengths, valid drops and backpressure
    ready_mode = 2;
    vdrop = 20;
    for (int b = 0; b < 4; b++) begin
      for (int f = 0; f < 10; f++)
        add_frame($urandom_range(N-1), 2'($urandom_range(3)), 1'($urandom_range(1)));
      run("random", 1500);
    end
    grant_log.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
